// File: rtl/bht_ckpt.sv
// Branch history table of saturating counters with a save/restore checkpoint engine that
// streams the packed table over a req/gnt/rvalid memory port.
module bht_ckpt #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned CNT_BITS        = 2,
  parameter int unsigned VLEN            = 64,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_restore_i,
  input  logic [ADDR_WIDTH-1:0]      ckpt_base_i,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned Ew      = CNT_BITS + 1;
  localparam int unsigned Epw     = DATA_WIDTH / Ew;
  localparam int unsigned NrWords = (NR_ENTRIES + Epw - 1) / Epw;
  localparam int unsigned Iw      = $clog2(NR_ENTRIES);
  localparam int unsigned Kw      = (NrWords > 1) ? $clog2(NrWords) : 1;
  localparam logic [CNT_BITS-1:0] CntMax  = '1;
  localparam logic [CNT_BITS-1:0] CntWeak = CNT_BITS'(1) << (CNT_BITS - 1);

  typedef enum logic [2:0] {StIdle, StSave, StRdReq, StRdWait, StDone} state_e;

  state_e                             r_state, w_state_nxt;
  logic [Kw-1:0]                      r_k;
  logic [ADDR_WIDTH-1:0]              r_base;
  logic [NR_ENTRIES-1:0]              r_valid;
  logic [NR_ENTRIES-1:0][CNT_BITS-1:0] r_cnt;

  logic                  w_k_inc;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_pack;
  logic [Iw-1:0]         w_upd_idx;
  logic [Iw-1:0]         w_row_base;
  logic [Epw-1:0][31:0]  w_slot_lin;
  logic [Epw-1:0][Iw-1:0] w_slot_idx;
  logic [Epw-1:0]        w_slot_ok;
  logic                  w_unused;

  assign busy_o     = (r_state != StIdle);
  assign done_o     = (r_state == StDone);
  assign w_last     = (r_k == Kw'(NrWords - 1));
  assign w_addr     = r_base + (ADDR_WIDTH'(r_k) * ADDR_WIDTH'(DATA_WIDTH / 8));
  assign w_upd_idx  = upd_pc_i[Iw:1];
  assign w_row_base = vpc_i[Iw:1] & ~Iw'(INSTR_PER_FETCH - 1);
  assign w_unused   = ^{vpc_i, upd_pc_i, mem_rdata_i, w_slot_lin};

  // Entries carried by the current memory word; slots past the table end stay unused.
  always_comb begin
    w_slot_lin = '0;
    w_slot_idx = '0;
    w_slot_ok  = '0;
    for (int j = 0; j < int'(Epw); j++) begin
      w_slot_lin[j] = 32'(r_k) * 32'(Epw) + 32'(j);
      w_slot_idx[j] = w_slot_lin[j][Iw-1:0];
      w_slot_ok[j]  = (w_slot_lin[j] < 32'(NR_ENTRIES));
    end
  end

  always_comb begin
    w_pack = '0;
    for (int j = 0; j < int'(Epw); j++) begin
      if (w_slot_ok[j]) begin
        w_pack[j*Ew +: Ew] = {r_valid[w_slot_idx[j]], r_cnt[w_slot_idx[j]]};
      end
    end
  end

  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    if (!busy_o) begin
      for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
        pred_valid_o[i] = r_valid[w_row_base | Iw'(i)];
        pred_taken_o[i] = r_cnt[w_row_base | Iw'(i)][CNT_BITS-1];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_inc     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (r_state)
      StIdle: begin
        if (ckpt_save_i) begin
          w_state_nxt = StSave;
        end else if (ckpt_restore_i) begin
          w_state_nxt = StRdReq;
        end
      end
      StSave: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_addr;
        mem_wdata_o = w_pack;
        if (mem_gnt_i) begin
          w_k_inc = 1'b1;
          if (w_last) w_state_nxt = StDone;
        end
      end
      StRdReq: begin
        mem_req_o  = 1'b1;
        mem_addr_o = w_addr;
        if (mem_gnt_i) w_state_nxt = StRdWait;
      end
      StRdWait: begin
        if (mem_rvalid_i) begin
          w_k_inc     = 1'b1;
          w_state_nxt = w_last ? StDone : StRdReq;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle) begin
        r_k <= '0;
        if (ckpt_save_i || ckpt_restore_i) r_base <= ckpt_base_i;
      end else if (w_k_inc) begin
        r_k <= r_k + Kw'(1);
      end
    end
  end

  // While busy the table only changes through restore writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (r_state == StIdle) begin
      if (flush_i) begin
        r_valid <= '0;
        r_cnt   <= {NR_ENTRIES{CntWeak}};
      end else if (upd_valid_i && !debug_mode_i) begin
        r_valid[w_upd_idx] <= 1'b1;
        if (upd_taken_i && (r_cnt[w_upd_idx] != CntMax)) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_BITS'(1);
        end else if (!upd_taken_i && (r_cnt[w_upd_idx] != '0)) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_BITS'(1);
        end
      end
    end else if ((r_state == StRdWait) && mem_rvalid_i) begin
      for (int j = 0; j < int'(Epw); j++) begin
        if (w_slot_ok[j]) begin
          r_valid[w_slot_idx[j]] <= mem_rdata_i[j*Ew + CNT_BITS];
          r_cnt[w_slot_idx[j]]   <= mem_rdata_i[j*Ew +: CNT_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_ckpt.sv
// Directed bench for bht_ckpt: training, saturation, save/restore streams, busy blocking,
// reset abort and flush, checked against a small reference table model.
module tb_bht_ckpt;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, debug_mode_i, upd_valid_i, upd_taken_i;
  logic [63:0] vpc_i, upd_pc_i, ckpt_base_i, mem_rdata_i;
  logic [1:0]  pred_valid_o, pred_taken_o;
  logic        ckpt_save_i, ckpt_restore_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o, done_o;
  logic [63:0] mem_addr_o, mem_wdata_o;

  int          n_total = 0;
  int          n_bad   = 0;
  logic        m_valid [64];
  logic [1:0]  m_cnt   [64];
  logic [63:0] saved   [4];
  logic [63:0] cap_addr[8];
  logic [63:0] cap_data[8];
  int          n_cap;

  bht_ckpt #(
    .NR_ENTRIES(64), .INSTR_PER_FETCH(2), .CNT_BITS(2),
    .VLEN(64), .ADDR_WIDTH(64), .DATA_WIDTH(64)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .vpc_i(vpc_i), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .ckpt_save_i(ckpt_save_i), .ckpt_restore_i(ckpt_restore_i), .ckpt_base_i(ckpt_base_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void m_reset();
    for (int e = 0; e < 64; e++) begin
      m_valid[e] = 1'b0;
      m_cnt[e]   = 2'b00;
    end
  endfunction

  function automatic void m_flush();
    for (int e = 0; e < 64; e++) begin
      m_valid[e] = 1'b0;
      m_cnt[e]   = 2'b10;
    end
  endfunction

  function automatic logic [63:0] m_word(input int k);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 21; j++) begin
      if (k * 21 + j < 64) w[j*3 +: 3] = {m_valid[k*21+j], m_cnt[k*21+j]};
    end
    return w;
  endfunction

  task automatic upd(input logic [63:0] pc, input bit taken, input bit dbg);
    int e;
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    debug_mode_i = dbg;
    tick();
    upd_valid_i  = 1'b0;
    debug_mode_i = 1'b0;
    e = int'(pc[6:1]);
    if (!dbg) begin
      m_valid[e] = 1'b1;
      if (taken && m_cnt[e] != 2'b11) m_cnt[e] = m_cnt[e] + 2'd1;
      else if (!taken && m_cnt[e] != 2'b00) m_cnt[e] = m_cnt[e] - 2'd1;
    end
  endtask

  task automatic check_pred(input string tag, input logic [63:0] pc, input logic [1:0] v,
                            input logic [1:0] t);
    vpc_i = pc;
    #1;
    check({tag, "_valid"}, pred_valid_o, v);
    check({tag, "_taken"}, pred_taken_o, t);
  endtask

  task automatic do_save(input string tag, input logic [63:0] base, input int stall,
                         input bit disturb);
    int          wc;
    bit          seen;
    logic [63:0] a0, d0;
    wc = 0; seen = 1'b0; n_cap = 0; a0 = '0; d0 = '0;
    ckpt_base_i = base;
    ckpt_save_i = 1'b1;
    tick();
    ckpt_save_i = 1'b0;
    ckpt_base_i = '0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (busy_o) begin
        check({tag, "_busy_predv"}, pred_valid_o, 2'b00);
        check({tag, "_busy_predt"}, pred_taken_o, 2'b00);
      end
      if (done_o) begin
        seen = 1'b1;
      end else if (mem_req_o) begin
        if (wc == 0) begin
          a0 = mem_addr_o;
          d0 = mem_wdata_o;
          check({tag, "_we"}, mem_we_o, 1'b1);
        end else begin
          check({tag, "_stall_addr"}, mem_addr_o, a0);
          check({tag, "_stall_data"}, mem_wdata_o, d0);
        end
        if (wc == stall) begin
          mem_gnt_i = 1'b1;
          if (n_cap < 8) begin
            cap_addr[n_cap] = a0;
            cap_data[n_cap] = d0;
          end
          n_cap++;
          wc = 0;
        end else begin
          wc++;
        end
      end
      if (disturb && cyc == 2) begin
        upd_valid_i    = 1'b1;
        upd_pc_i       = '0;
        upd_taken_i    = 1'b0;
        flush_i        = 1'b1;
        ckpt_restore_i = 1'b1;
      end
      tick();
      mem_gnt_i = 1'b0; upd_valid_i = 1'b0; flush_i = 1'b0; ckpt_restore_i = 1'b0;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_done_once"}, done_o, 1'b0);
    check({tag, "_busy_after"}, busy_o, 1'b0);
    check({tag, "_nwrites"}, n_cap, 4);
    for (int w = 0; w < 4; w++) begin
      check({tag, "_addr"}, cap_addr[w], base + 64'(w) * 64'd8);
      check({tag, "_data"}, cap_data[w], m_word(w));
    end
  endtask

  task automatic do_restore(input string tag, input logic [63:0] base, input int lat);
    bit pend, seen;
    int lc, n;
    pend = 1'b0; seen = 1'b0; lc = 0; n = 0;
    ckpt_base_i    = base;
    ckpt_restore_i = 1'b1;
    tick();
    ckpt_restore_i = 1'b0;
    ckpt_base_i    = '0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (done_o) begin
        seen = 1'b1;
      end else if (pend) begin
        if (lc == lat - 1) begin
          mem_rvalid_i = 1'b1;
          if (n < 4) mem_rdata_i = saved[n];
          n++;
          pend = 1'b0;
        end else begin
          lc++;
        end
      end else if (mem_req_o) begin
        check({tag, "_we"}, mem_we_o, 1'b0);
        check({tag, "_wdata"}, mem_wdata_o, 64'd0);
        check({tag, "_addr"}, mem_addr_o, base + 64'(n) * 64'd8);
        mem_gnt_i = 1'b1;
        pend = 1'b1;
        lc = 0;
      end
      tick();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_busy_after"}, busy_o, 1'b0);
    check({tag, "_nreads"}, n, 4);
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 21; j++) begin
        if (w * 21 + j < 64) begin
          m_valid[w*21+j] = saved[w][j*3+2];
          m_cnt[w*21+j]   = saved[w][j*3 +: 2];
        end
      end
    end
  endtask

  initial begin
    int g;
    rst_ni = 1'b0;
    flush_i = 1'b0; debug_mode_i = 1'b0; vpc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0;
    upd_taken_i = 1'b0; ckpt_save_i = 1'b0; ckpt_restore_i = 1'b0; ckpt_base_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    m_reset();
    repeat (2) tick();
    check("rst_req", mem_req_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, 64'd0);
    check("rst_wdata", mem_wdata_o, 64'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check_pred("rst_pred", 64'h0, 2'b00, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Saturation at entry 0
    repeat (4) upd(64'h0, 1'b1, 1'b0);
    check_pred("s1_sat_hi", 64'h0, 2'b01, 2'b01);
    upd(64'h0, 1'b0, 1'b0);
    check_pred("s1_cnt2", 64'h0, 2'b01, 2'b01);
    upd(64'h0, 1'b0, 1'b0);
    check_pred("s1_cnt1", 64'h0, 2'b01, 2'b00);
    upd(64'h0, 1'b0, 1'b0);
    upd(64'h0, 1'b0, 1'b0);
    upd(64'h0, 1'b1, 1'b0);
    check_pred("s1_floor", 64'h0, 2'b01, 2'b00);
    upd(64'h0, 1'b1, 1'b0);
    upd(64'h0, 1'b1, 1'b0);
    upd(64'h2A, 1'b1, 1'b0);
    check_pred("s2_pre_e21", 64'h2A, 2'b10, 2'b00);

    // Save with 3-cycle grant stalls
    vpc_i = 64'h0;
    do_save("s2", 64'h8000_0000, 3, 1'b0);
    for (int w = 0; w < 4; w++) saved[w] = cap_data[w];
    check("s2_w0_lo", 64'(saved[0][2:0]), 64'b111);
    check("s2_w1_lo", 64'(saved[1][2:0]), 64'b101);
    check("s2_w3_hi", saved[3] >> 3, 64'd0);

    // Busy blocking: update, flush and restore during a save are dropped
    vpc_i = 64'h0;
    do_save("s4", 64'h8000_0000, 1, 1'b1);
    check_pred("s4_e0", 64'h0, 2'b01, 2'b01);
    check_pred("s4_e21", 64'h2A, 2'b10, 2'b00);
    tick();
    check("s4_no_restore", busy_o, 1'b0);

    // Flush, stray rvalid in idle, then restore with 2-cycle read latency
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    m_flush();
    check_pred("s3_flushed", 64'h0, 2'b00, 2'b11);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = '1;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    check_pred("s3_idle_rvalid", 64'h0, 2'b00, 2'b11);
    do_restore("s3", 64'h8000_0000, 2);
    check_pred("s3_e0", 64'h0, 2'b01, 2'b01);
    check_pred("s3_e21", 64'h2A, 2'b10, 2'b00);
    check_pred("s3_e8", 64'h10, 2'b00, 2'b00);
    vpc_i = 64'h0;
    do_save("s3v", 64'h4000, 0, 1'b0);

    // Reset in the middle of a save after two grants
    vpc_i = 64'h0;
    ckpt_base_i = 64'h8000_0000;
    ckpt_save_i = 1'b1;
    tick();
    ckpt_save_i = 1'b0;
    g = 0;
    for (int cyc = 0; cyc < 50 && g < 2; cyc++) begin
      if (mem_req_o) begin
        mem_gnt_i = 1'b1;
        g++;
      end
      tick();
      mem_gnt_i = 1'b0;
    end
    check("s5_grants", 64'(g), 64'd2);
    check("s5_req_pre", mem_req_o, 1'b1);
    check("s5_addr_pre", mem_addr_o, 64'h8000_0010);
    #2;
    rst_ni = 1'b0;
    #1;
    check("s5_req_rst", mem_req_o, 1'b0);
    check("s5_busy_rst", busy_o, 1'b0);
    check("s5_addr_rst", mem_addr_o, 64'd0);
    m_reset();
    check_pred("s5_pred_rst", 64'h0, 2'b00, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    vpc_i = 64'h0;
    do_save("s5", 64'h8000_0000, 1, 1'b0);

    // Flush after training; flush beats a same-cycle update; debug blocks updates
    upd(64'h4, 1'b1, 1'b0);
    upd(64'h4, 1'b1, 1'b0);
    upd(64'h7E, 1'b1, 1'b0);
    check_pred("s6_trained", 64'h4, 2'b01, 2'b01);
    flush_i     = 1'b1;
    upd_valid_i = 1'b1;
    upd_pc_i    = 64'h4;
    upd_taken_i = 1'b0;
    tick();
    flush_i     = 1'b0;
    upd_valid_i = 1'b0;
    m_flush();
    upd(64'h4, 1'b0, 1'b1);
    check_pred("s6_flush_dbg", 64'h4, 2'b00, 2'b11);
    vpc_i = 64'h0;
    do_save("s6", 64'h1000, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
